// File: rtl/dmem_load_arbiter.sv
// rtl/dmem_load_arbiter.sv - bank I write-port arbiter (sample stream vs host) and DSP reset sequencer
module dmem_load_arbiter #(
  parameter int          FRAME_LEN  = 64,
  parameter logic [14:0] BASE_ADDR  = 15'd0,
  parameter int          RUN_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  input  logic        h_req,
  input  logic [14:0] h_addr,
  input  logic [15:0] h_data,
  output logic        h_gnt,
  output logic        write_en_1,
  output logic [14:0] write_addr_1,
  output logic [15:0] write_data_1,
  output logic        dsp_rst,
  output logic        frame_done,
  output logic        busy
);

  localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t           state, state_next;
  logic [15:0]      wr_ptr, wr_ptr_next;
  logic [RUN_W-1:0] run_cnt, run_cnt_next;
  logic             rr_last_host;
  logic             stream_req;
  logic             s_gnt;
  logic             h_win;
  logic             fill_last;
  logic             run_last;

  // Grants are combinational; on a tie the requester that did not win last time goes first.
  always_comb begin
    stream_req = (state == FILL) && s_valid;
    s_gnt      = !rst && stream_req && (!h_req || rr_last_host);
    h_win      = !rst && h_req && !s_gnt;
    fill_last  = s_gnt && (wr_ptr == 16'(FRAME_LEN - 1));
    run_last   = (state == RUN) && (run_cnt == RUN_W'(RUN_CYCLES - 1));
  end

  assign s_ready = s_gnt;
  assign h_gnt   = h_win;
  assign busy    = (state != IDLE);

  always_comb begin
    state_next   = state;
    wr_ptr_next  = wr_ptr;
    run_cnt_next = run_cnt;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next  = FILL;
          wr_ptr_next = '0;
        end
      end
      FILL: begin
        if (s_gnt) wr_ptr_next = wr_ptr + 16'd1;
        if (fill_last) begin
          state_next   = RUN;
          run_cnt_next = '0;
        end
      end
      RUN: begin
        if (run_last) begin
          state_next  = enable ? FILL : IDLE;
          wr_ptr_next = '0;
        end else begin
          run_cnt_next = run_cnt + RUN_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      run_cnt      <= '0;
      rr_last_host <= 1'b1;
      write_en_1   <= 1'b0;
      write_addr_1 <= '0;
      write_data_1 <= '0;
      dsp_rst      <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      state      <= state_next;
      wr_ptr     <= wr_ptr_next;
      run_cnt    <= run_cnt_next;
      write_en_1 <= s_gnt || h_win;
      if (s_gnt) begin
        write_addr_1 <= BASE_ADDR + wr_ptr[14:0];
        write_data_1 <= s_data;
      end else if (h_win) begin
        write_addr_1 <= h_addr;
        write_data_1 <= h_data;
      end
      // Round-robin pointer only moves when both sides actually contended.
      if (stream_req && h_req) rr_last_host <= h_win;
      dsp_rst    <= (state_next != RUN);
      frame_done <= fill_last;
    end
  end

endmodule

// File: tb/tb_dmem_load_arbiter.sv
// tb/tb_dmem_load_arbiter.sv - self-checking bench for dmem_load_arbiter
module tb_dmem_load_arbiter;

  localparam int FL = 4;
  localparam int RC = 8;
  localparam logic [14:0] BASE_A = 15'h0100;
  localparam logic [14:0] BASE_B = 15'h7FFE;

  logic        clk = 1'b0;
  logic        rst, enable, s_valid, h_req;
  logic [15:0] s_data, h_data;
  logic [14:0] h_addr;

  logic        s_ready_a, h_gnt_a, we_a, dsp_rst_a, fd_a, busy_a;
  logic [14:0] waddr_a;
  logic [15:0] wdata_a;
  logic        s_ready_b, h_gnt_b, we_b, dsp_rst_b, fd_b, busy_b;
  logic [14:0] waddr_b;
  logic [15:0] wdata_b;

  always #5 clk = ~clk;

  dmem_load_arbiter #(.FRAME_LEN(FL), .BASE_ADDR(BASE_A), .RUN_CYCLES(RC)) u_a (
    .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_a), .h_req(h_req), .h_addr(h_addr), .h_data(h_data), .h_gnt(h_gnt_a),
    .write_en_1(we_a), .write_addr_1(waddr_a), .write_data_1(wdata_a),
    .dsp_rst(dsp_rst_a), .frame_done(fd_a), .busy(busy_a));

  dmem_load_arbiter #(.FRAME_LEN(FL), .BASE_ADDR(BASE_B), .RUN_CYCLES(RC)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_b), .h_req(h_req), .h_addr(h_addr), .h_data(h_data), .h_gnt(h_gnt_b),
    .write_en_1(we_b), .write_addr_1(waddr_b), .write_data_1(wdata_b),
    .dsp_rst(dsp_rst_b), .frame_done(fd_b), .busy(busy_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: frame phase as plain flags and counters.
  bit          m_init = 0;
  bit          m_filling, m_running, m_host_last;
  int          m_count, m_run_left;
  bit          e_we, e_fd, e_host;
  int          e_idx;
  logic [14:0] e_haddr;
  logic [15:0] e_data;
  logic [1:0]  mg;

  function automatic logic [1:0] model_grant();
    bit gs, gh;
    gs = !rst && m_filling && s_valid && (!h_req || m_host_last);
    gh = !rst && h_req && !gs;
    return {gs, gh};
  endfunction

  function automatic logic [14:0] exp_addr(input logic [14:0] base);
    logic [14:0] t;
    t = base + 15'(e_idx);
    return e_host ? e_haddr : t;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_filling = 0; m_running = 0; m_host_last = 1;
      m_count = 0; m_run_left = 0; e_we = 0; e_fd = 0;
    end else begin
      mg = model_grant();
      e_we = |mg;
      e_fd = 0;
      if (mg[1]) begin e_host = 0; e_idx = m_count; e_data = s_data; m_count++; end
      if (mg[0]) begin e_host = 1; e_haddr = h_addr; e_data = h_data; end
      if (m_filling && s_valid && h_req) m_host_last = mg[0];
      if (m_running) begin
        m_run_left--;
        if (m_run_left == 0) begin m_running = 0; m_filling = enable; m_count = 0; end
      end else if (m_filling) begin
        if (m_count == FL) begin m_filling = 0; m_running = 1; m_run_left = RC; e_fd = 1; end
      end else if (enable) begin
        m_filling = 1; m_count = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      mg = model_grant();
      chk("s_ready_a", s_ready_a, mg[1]);   chk("s_ready_b", s_ready_b, mg[1]);
      chk("h_gnt_a", h_gnt_a, mg[0]);       chk("h_gnt_b", h_gnt_b, mg[0]);
      chk("we_a", we_a, e_we);              chk("we_b", we_b, e_we);
      chk("dsp_rst_a", dsp_rst_a, !m_running); chk("dsp_rst_b", dsp_rst_b, !m_running);
      chk("frame_done_a", fd_a, e_fd);      chk("frame_done_b", fd_b, e_fd);
      chk("busy_a", busy_a, m_filling || m_running);
      chk("busy_b", busy_b, m_filling || m_running);
      if (e_we) begin
        chk("waddr_a", waddr_a, exp_addr(BASE_A)); chk("wdata_a", wdata_a, e_data);
        chk("waddr_b", waddr_b, exp_addr(BASE_B)); chk("wdata_b", wdata_b, e_data);
      end
    end
  end

  // Observation logs for the hand-computed expectations.
  logic [14:0] log_a_addr[$], log_b_addr[$];
  logic [15:0] log_a_data[$];
  bit          gseq[$];
  int          fd_cnt = 0;
  int          low_cnt = 0;

  always @(negedge clk) begin
    if (we_a) begin log_a_addr.push_back(waddr_a); log_a_data.push_back(wdata_a); end
    if (we_b) log_b_addr.push_back(waddr_b);
    if (fd_a) fd_cnt++;
    if (!dsp_rst_a) low_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    log_a_addr.delete(); log_a_data.delete(); log_b_addr.delete(); gseq.delete();
  endtask

  task automatic feed(input logic [15:0] d0, input int n, input bit with_host, input logic [15:0] hd0);
    int sent, hsent, cyc;
    sent = 0; hsent = 0; cyc = 0;
    s_valid = 1'b1; s_data = d0;
    h_req = with_host; h_addr = 15'h7000; h_data = hd0;
    while (sent < n && cyc < 200) begin
      @(negedge clk);
      if (s_ready_a) begin gseq.push_back(1'b0); sent++; end
      if (h_gnt_a) begin gseq.push_back(1'b1); hsent++; end
      tick();
      s_data = d0 + 16'(sent);
      h_data = hd0 + 16'(hsent);
      cyc++;
    end
    s_valid = 1'b0; h_req = 1'b0;
    chk("feed_samples", sent, n);
  endtask

  task automatic wait_run_end();
    int n;
    n = 0;
    while (dsp_rst_a == 1'b0 && n < 100) begin tick(); n++; end
    chk("run_end", dsp_rst_a, 1);
  endtask

  logic [14:0] exp_a2 [4] = '{15'h0100, 15'h0101, 15'h0102, 15'h0103};
  logic [14:0] exp_b2 [4] = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
  logic [14:0] exp_a3 [4] = '{15'h0100, 15'h7000, 15'h0101, 15'h7000};
  logic [15:0] exp_d3 [4] = '{16'h0040, 16'hA000, 16'h0041, 16'hA001};
  int fd_before;

  initial begin
    rst = 1; enable = 0; s_valid = 0; s_data = 0; h_req = 0; h_addr = 0; h_data = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_addr", waddr_a, 0); chk("rst_data", wdata_a, 0);
    chk("rst_dsp", dsp_rst_a, 1); chk("rst_busy", busy_a, 0);
    tick();
    rst = 0; s_valid = 1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_s_ready", s_ready_a, 0); chk("idle_we", we_a, 0); chk("idle_dsp", dsp_rst_a, 1);
      tick();
    end
    s_valid = 0;

    clear_logs(); low_cnt = 0; fd_cnt = 0;
    enable = 1;
    feed(16'd25, 4, 0, 16'h0);
    enable = 0;
    h_req = 1; h_addr = 15'h0005; h_data = 16'hBEEF;
    @(negedge clk);
    chk("run_h_gnt", h_gnt_a, 1);
    tick();
    h_req = 0;
    @(negedge clk);
    chk("run_h_we", we_a, 1); chk("run_h_addr", waddr_a, 15'h0005);
    chk("run_h_data", wdata_a, 16'hBEEF); chk("run_h_dsp", dsp_rst_a, 0);
    tick();
    wait_run_end();
    chk("dsp_low_cycles", low_cnt, RC);
    chk("frame_done_count", fd_cnt, 1);
    chk("log_len", log_a_addr.size(), 5);
    if (log_a_addr.size() >= 5 && log_b_addr.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("frame_addr_a", log_a_addr[i], exp_a2[i]);
        chk("frame_data_a", log_a_data[i], 25 + i);
        chk("frame_addr_wrap_b", log_b_addr[i], exp_b2[i]);
      end
      chk("host_log_addr", log_a_addr[4], 15'h0005);
      chk("host_log_data", log_a_data[4], 16'hBEEF);
    end

    repeat (2) tick();
    clear_logs();
    enable = 1;
    tick();
    feed(16'h0040, 4, 1, 16'hA000);
    enable = 0;
    wait_run_end();
    chk("rr_len", (gseq.size() >= 4 && log_a_addr.size() >= 4) ? 1 : 0, 1);
    if (gseq.size() >= 4 && log_a_addr.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr_grant_order", gseq[i], i % 2);
        chk("rr_addr", log_a_addr[i], exp_a3[i]);
        chk("rr_data", log_a_data[i], exp_d3[i]);
      end
    end

    repeat (2) tick();
    fd_before = fd_cnt;
    enable = 1;
    feed(16'h0200, 2, 0, 16'h0);
    rst = 1; enable = 0;
    tick();
    @(negedge clk);
    chk("abort_busy", busy_a, 0); chk("abort_dsp", dsp_rst_a, 1);
    chk("abort_we", we_a, 0);     chk("abort_fd", fd_a, 0);
    tick();
    rst = 0;
    chk("abort_no_fd", fd_cnt, fd_before);
    clear_logs();
    enable = 1;
    feed(16'h0300, 4, 0, 16'h0);
    enable = 0;
    wait_run_end();
    chk("refill_fd", fd_cnt, fd_before + 1);
    chk("refill_len", log_a_addr.size(), 4);
    if (log_a_addr.size() >= 1 && log_b_addr.size() >= 1) begin
      chk("refill_addr_a", log_a_addr[0], 15'h0100);
      chk("refill_data_a", log_a_data[0], 16'h0300);
      chk("refill_addr_b", log_b_addr[0], 15'h7FFE);
    end

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
